// File: rtl/riscv_pkg.sv
// Shared types for the memory-port arbiter: FSM states and transaction owner.
package riscv_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_WAIT_IF = 2'd1,
        ARB_WAIT_DM = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

    // Wait state that follows a grant to the given owner.
    function automatic arb_state_t wait_state_for(arb_owner_t owner);
        return (owner == OWN_IF) ? ARB_WAIT_IF : ARB_WAIT_DM;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access,
// one outstanding transaction at a time, data first with bounded fetch starvation.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int IF_STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wstrb,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                err_spur
);

    localparam int CNT_W = $clog2(IF_STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IF_STARVE_MAX);

    arb_state_t       state_reg, state_next;
    logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
    logic             store_reg, store_next;
    logic             err_spur_reg, err_spur_next;

    arb_owner_t       owner;
    logic             idle;
    logic             granted;

    // Request side: everything is gated by rst_n so the block is silent while held in reset.
    always_comb begin
        idle      = rst_n && (state_reg == ARB_IDLE);
        owner     = (if_req && (!dm_req || (starve_cnt_reg == CNT_MAX))) ? OWN_IF : OWN_DM;
        mem_req   = idle && (if_req || dm_req);
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (mem_req) begin
            if (owner == OWN_IF) begin
                mem_addr  = if_addr;
                mem_wstrb = '1;
            end else begin
                mem_we    = dm_we;
                mem_addr  = dm_addr;
                mem_wdata = dm_wdata;
                mem_wstrb = dm_wstrb;
            end
        end
        granted = mem_req && mem_ready;
        if_gnt  = granted && (owner == OWN_IF);
        dm_gnt  = granted && (owner == OWN_DM);
    end

    // Response side: route mem_rvalid to whoever owns the outstanding transaction.
    always_comb begin
        if_rvalid = rst_n && (state_reg == ARB_WAIT_IF) && mem_rvalid;
        dm_rvalid = rst_n && (state_reg == ARB_WAIT_DM) && mem_rvalid;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        dm_rdata  = (dm_rvalid && !store_reg) ? mem_rdata : '0;
    end

    always_comb begin
        state_next = state_reg;
        store_next = store_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (granted) begin
                    state_next = wait_state_for(owner);
                    store_next = (owner == OWN_DM) && dm_we;
                end
            end
            ARB_WAIT_IF, ARB_WAIT_DM: begin
                if (mem_rvalid) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase

        starve_cnt_next = starve_cnt_reg;
        if (!if_req || if_gnt) begin
            starve_cnt_next = '0;
        end else if (dm_gnt && (starve_cnt_reg != CNT_MAX)) begin
            starve_cnt_next = starve_cnt_reg + CNT_W'(1);
        end

        // A response with nothing outstanding (including one orphaned by reset) is sticky.
        err_spur_next = err_spur_reg || (mem_rvalid && (state_reg == ARB_IDLE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ARB_IDLE;
            starve_cnt_reg <= '0;
            store_reg      <= 1'b0;
            err_spur_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            store_reg      <= store_next;
            err_spur_reg   <= err_spur_next;
        end
    end

    assign err_spur = err_spur_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a latency-programmable memory model,
// requester drivers fed from queues, and an expected-grant-order queue.
module tb_mem_port_arbiter;

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_wstrb;
    logic        mem_req, mem_we, mem_ready, mem_rvalid, err_spur;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .IF_STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .err_spur(err_spur)
    );

    txn_t if_q[$], dm_q[$], exp_q[$], resp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   lat = 2;
    int   gnt_cyc = 0;
    int   last_dm_rv_cyc = 0;
    int   if_raise_cyc = 0;
    logic chk_lat0 = 1'b0;
    logic chk_bubble = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : 32'h1000_0000 + a;
    endfunction

    function automatic txn_t mk(input logic is_dm, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                input logic [31:0] rdata);
        txn_t t;
        t.is_dm = is_dm; t.we = we; t.addr = addr; t.wdata = wdata; t.wstrb = wstrb; t.rdata = rdata;
        return t;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: accepts on mem_req & mem_ready, answers lat cycles later.
    logic [31:0] mem_arr [0:255];
    logic        mem_init_done = 1'b0;
    logic        pend = 1'b0;
    int          pcnt = 0;
    logic [31:0] rsp_data = 32'h0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= pat(32'(i * 4));
            mem_init_done <= 1'b1;
        end
        if (mem_req && mem_ready && !pend) begin
            pend <= 1'b1;
            pcnt <= lat - 1;
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) mem_arr[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                rsp_data <= 32'hBAD0_0000 ^ 32'(cyc);
            end else begin
                rsp_data <= mem_arr[mem_addr[9:2]];
            end
        end else if (pend) begin
            if (pcnt == 0) pend <= 1'b0;
            else pcnt <= pcnt - 1;
        end
    end

    assign mem_rvalid = pend && (pcnt == 0);
    assign mem_rdata  = rsp_data;

    // Requesters: hold the head of each queue until granted.
    initial begin : driver
        logic itk, dtk, prev_if;
        prev_if = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
        forever begin
            @(negedge clk);
            itk = if_gnt;
            dtk = dm_gnt;
            @(posedge clk);
            #1;
            if (itk && if_q.size() != 0) void'(if_q.pop_front());
            if (dtk && dm_q.size() != 0) void'(dm_q.pop_front());
            if_req  = (if_q.size() != 0);
            if_addr = if_req ? if_q[0].addr : '0;
            if (if_req && !prev_if) if_raise_cyc = cyc;
            prev_if = if_req;
            dm_req   = (dm_q.size() != 0);
            dm_we    = dm_req ? dm_q[0].we : 1'b0;
            dm_addr  = dm_req ? dm_q[0].addr : '0;
            dm_wdata = dm_req ? dm_q[0].wdata : '0;
            dm_wstrb = dm_req ? dm_q[0].wstrb : '0;
        end
    end

    txn_t mon_e, mon_r;

    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("gnt_vs_mem", {63'd0, if_gnt | dm_gnt}, {63'd0, mem_req & mem_ready});
            check_eq("gnt_onehot", {63'd0, if_gnt & dm_gnt}, 64'd0);
            if (mem_req && mem_ready) begin
                check_eq("gnt_expected", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check_eq("gnt_port_dm", {63'd0, dm_gnt}, {63'd0, mon_e.is_dm});
                    check_eq("mem_addr", {32'd0, mem_addr}, {32'd0, mon_e.addr});
                    check_eq("mem_we", {63'd0, mem_we}, {63'd0, mon_e.we});
                    check_eq("mem_wstrb", {60'd0, mem_wstrb}, {60'd0, mon_e.is_dm ? mon_e.wstrb : 4'hF});
                    if (mon_e.we) check_eq("mem_wdata", {32'd0, mem_wdata}, {32'd0, mon_e.wdata});
                    if (chk_lat0 && if_gnt) check_eq("if_req2gnt", 64'(cyc - if_raise_cyc), 64'd0);
                    if (chk_bubble && if_gnt) check_eq("if_bubble", 64'(cyc - last_dm_rv_cyc), 64'd1);
                    gnt_cyc = cyc;
                    resp_q.push_back(mon_e);
                end
            end
            if (mem_rvalid)
                check_eq("rvalid_routed", {63'd0, if_rvalid | dm_rvalid}, {63'd0, resp_q.size() != 0});
            if (if_rvalid || dm_rvalid) begin
                check_eq("rsp_expected", {63'd0, resp_q.size() != 0}, 64'd1);
                if (resp_q.size() != 0) begin
                    mon_r = resp_q.pop_front();
                    check_eq("rsp_port_dm", {63'd0, dm_rvalid}, {63'd0, mon_r.is_dm});
                    check_eq("rsp_data", {32'd0, dm_rvalid ? dm_rdata : if_rdata}, {32'd0, mon_r.rdata});
                    check_eq("rsp_latency", 64'(cyc - gnt_cyc), 64'(lat));
                    if (dm_rvalid) last_dm_rv_cyc = cyc;
                    $display("txn %s we=%0d addr=%h rdata=%h cyc=%0d", mon_r.is_dm ? "DM" : "IF",
                             mon_r.we, mon_r.addr, dm_rvalid ? dm_rdata : if_rdata, cyc);
                end
            end
        end
    end

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() + resp_q.size() + if_q.size() + dm_q.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_in_budget", {63'd0, n < budget}, 64'd1);
        @(negedge clk);
    endtask

    function automatic logic any_out();
        return |{if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
                 mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, err_spur};
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        txn_t t;
        int   n;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", {63'd0, any_out()}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);

        // Fetch alone: granted immediately, data two cycles later.
        lat = 2;
        chk_lat0 = 1'b1;
        t = mk(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 32'h0050_0093);
        exp_q.push_back(t); if_q.push_back(t);
        wait_done(50);
        chk_lat0 = 1'b0;

        // Collision: partial store wins, fetch follows after one idle cycle.
        lat = 3;
        chk_bubble = 1'b1;
        t = mk(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011, 32'h0);
        exp_q.push_back(t); dm_q.push_back(t);
        t = mk(1'b0, 1'b0, 32'h40, 32'h0, 4'hF, 32'h1000_0040);
        exp_q.push_back(t); if_q.push_back(t);
        wait_done(50);
        chk_bubble = 1'b0;

        // Read back the partially written word.
        lat = 1;
        t = mk(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 32'h1000_BEEF);
        exp_q.push_back(t); dm_q.push_back(t);
        wait_done(50);

        // Starvation: 4 data grants, then the waiting fetch, and the count restarts.
        for (int k = 0; k < 9; k++)
            dm_q.push_back(mk(1'b1, 1'b0, 32'h200 + 32'(4 * k), 32'h0, 4'hF, pat(32'h200 + 32'(4 * k))));
        if_q.push_back(mk(1'b0, 1'b0, 32'h80, 32'h0, 4'hF, pat(32'h80)));
        if_q.push_back(mk(1'b0, 1'b0, 32'h84, 32'h0, 4'hF, pat(32'h84)));
        for (int k = 0; k < 4; k++) exp_q.push_back(dm_q[k]);
        exp_q.push_back(if_q[0]);
        for (int k = 4; k < 8; k++) exp_q.push_back(dm_q[k]);
        exp_q.push_back(if_q[1]);
        exp_q.push_back(dm_q[8]);
        wait_done(200);

        // Backpressure: request held with a stable payload, no grant until ready.
        #1 mem_ready = 1'b0;
        t = mk(1'b1, 1'b1, 32'h304, 32'h1234_5678, 4'b1100, 32'h0);
        exp_q.push_back(t); dm_q.push_back(t);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("bp_mem_req", {63'd0, mem_req}, 64'd1);
            check_eq("bp_mem_addr", {32'd0, mem_addr}, 64'h304);
            check_eq("bp_mem_wdata", {32'd0, mem_wdata}, 64'h1234_5678);
            check_eq("bp_mem_wstrb", {60'd0, mem_wstrb}, 64'hC);
            check_eq("bp_no_gnt", {63'd0, dm_gnt | if_gnt}, 64'd0);
        end
        @(posedge clk);
        #2 mem_ready = 1'b1;
        wait_done(50);

        // Reset mid-transaction: outputs drop at once, the late response is flagged.
        check_eq("err_spur_clean", {63'd0, err_spur}, 64'd0);
        lat = 5;
        t = mk(1'b1, 1'b0, 32'h308, 32'h0, 4'hF, pat(32'h308));
        exp_q.push_back(t); dm_q.push_back(t);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dm_gnt && n < 20);
        check_eq("rst_test_gnt", {63'd0, dm_gnt}, 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_outputs", {63'd0, any_out()}, 64'd0);
        resp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("err_spur_set", {63'd0, err_spur}, 64'd1);
        check_eq("no_rvalid_after", {63'd0, if_rvalid | dm_rvalid}, 64'd0);
        check_eq("queues_empty", 64'(exp_q.size() + resp_q.size() + if_q.size() + dm_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
